frame_egress: RTL
=================

# frame_egress

Egress stage directly downstream of the frame buffer. It accepts one frame descriptor at a time from the switch FSM and rewinds the frame buffer read pointer to the frame start. It then reads the frame's 20-bit words and emits them as a 16-bit AXI-stream with `tlast` on the final beat, honouring downstream `tready` backpressure through a small skid buffer.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: frame buffer address width. Pointers are `ADDR_WIDTH+1` bits.
- `SKID_DEPTH`, 4: skid buffer entries. Must be a power of two and ≥ 2.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: synchronous, active-low reset, sampled on `posedge clk`.
- `cmd_valid` in 1: a frame descriptor is present.
- `cmd_ready` out 1: the block accepts a descriptor; high only in IDLE.
- `cmd_start_ptr` in `ADDR_WIDTH+1`: pointer to the frame's first word.
- `cmd_len` in `ADDR_WIDTH`: frame length in 16-bit words.
- `frame_rrst` out 1: one-cycle pulse that loads the frame buffer read pointer.
- `frame_rst_rptr` out `ADDR_WIDTH+1`: value to load; equals the latched `cmd_start_ptr`.
- `frame_ren` out 1: frame buffer read enable.
- `frame_rdata` in 20: frame buffer read data, valid 1 cycle after `frame_ren`.
- `last_entry` in 1: the frame buffer holds only one unread word.
- `egress_pkt` out `axis_source_t`: carries `tdata[15:0]`, `tvalid`, `tlast`.
- `egress_tready` in 1: downstream accepts a beat.
- `underrun` out 1: one-cycle pulse when a frame was truncated.
- `busy` out 1: the block is not in IDLE.

## Operation
- States are IDLE, REWIND, STREAM and DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cmd_start_ptr` and `cmd_len`.
  - If `cmd_len`==0: pulse `underrun`, stay in IDLE, emit nothing.
  - Otherwise go to REWIND.
- REWIND (exactly 1 cycle):
  - `frame_rrst`=1, `frame_rst_rptr`=latched start.
  - Load `rd_left`=`cmd_len` and `tx_left`=`cmd_len`.
  - Go to STREAM.
- STREAM:
  - `frame_ren`=1 iff `rd_left`≠0 and `skid_count + inflight` < `SKID_DEPTH`.
  - `inflight` is the ren issued in the previous cycle.
  - Each `frame_ren` decrements `rd_left`.
  - Each returned word is pushed as `frame_rdata[15:0]`; bits [19:16] are ignored.
  - When `rd_left` reaches 0, go to DRAIN.
- Underrun:
  - Condition: in STREAM, `frame_ren` is issued while `last_entry`=1 and `rd_left`>1.
  - Set `rd_left`:=0 and `tx_left`:=words issued so far minus those already sent.
  - Pulse `underrun` and go to DRAIN.
  - The last buffered word still carries `tlast`.
- DRAIN:
  - No reads.
  - When the beat with `tx_left`==1 is handshaken, go to IDLE.
- Output:
  - `tvalid` = skid buffer not empty.
  - `tdata` = skid buffer head.
  - `tlast` = (`tx_left`==1).
  - A beat transfers on `tvalid & egress_tready`, which decrements `tx_left`.
- Pointer arithmetic wraps modulo 2^(`ADDR_WIDTH`+1); no saturation anywhere.
- While not in IDLE, `cmd_valid` is ignored and `cmd_ready`=0.

## Timing
- Reset (`reset_n`=0 at a clock edge):
  - State goes to IDLE.
  - Skid buffer is emptied; counters clear.
  - Outputs: `cmd_ready`=1, `frame_rrst`=0, `frame_rst_rptr`=0, `frame_ren`=0, `tvalid`=0, `tlast`=0, `underrun`=0, `busy`=0.
- Reset mid-frame aborts the frame with no `tlast`; the in-flight read is discarded.
- Latency from descriptor acceptance at edge T:
  - `frame_rrst` high in cycle T+1.
  - First `frame_ren` in T+2.
  - Word available in T+3.
  - First `tvalid` in T+4.
- With `egress_tready` held at 1, the block sustains 1 beat per cycle.
- A frame of N words finishes in IDLE at T+N+4.
- The next descriptor is accepted in the cycle `cmd_ready` is seen high after that.
- `tvalid` rules:
  - Never deasserts without a handshake.
  - `tdata` and `tlast` are stable while stalled.
- Simultaneous push and pop on a full skid buffer is legal.
- Reads are throttled so the buffer never overflows.

## Structure
- Add `egress_cmd_t` (start_ptr, len) to `packet_filter.svh`.
- `axis_source_t` is reused unchanged.
- One sub-module: `egress_skid_buf`, a synchronous FIFO with `SKID_DEPTH`×16 bits, push/pop/count, and a combinational head.

## Test plan
- Reset then idle → `cmd_ready`=1, `tvalid`=0, no `frame_ren` for 20 cycles.
- cmd start=0x010, len=4, `tready`=1 → `frame_rrst` at T+1 with rptr=0x010; 4 beats at T+4..T+7 with data from words 0x010..0x013; `tlast` only on the 4th; `busy` falls at T+8.
- len=32 with `tready` toggling 1,0,0,1,… → exactly 32 beats in order, no data changes while stalled, `frame_ren` count = 32.
- start=0xFFE, len=5 → reads wrap to 0x000; 5 beats in address order.
- len=10 with `last_entry`=1 asserted at the 6th read → `underrun` pulse; 6 beats, the 6th with `tlast`; state returns to IDLE.
- len=0 → `underrun` pulse, no `frame_rrst`, no beats; `reset_n`=0 during beat 3 of a len=8 frame → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/frame_egress_pkg.sv
// Shared types for the frame egress stage: AXI-stream source beat, egress descriptor and
// FSM state encodings.
package frame_egress_pkg;

  typedef struct packed {
    logic [15:0] tdata;
    logic        tvalid;
    logic        tlast;
  } axis_source_t;

  // Descriptor view at the default 11-bit frame buffer address width.
  localparam int unsigned EgressAddrWidth = 11;

  typedef struct packed {
    logic [EgressAddrWidth:0]   start_ptr;
    logic [EgressAddrWidth-1:0] len;
  } egress_cmd_t;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRewind = 2'd1;
  localparam logic [1:0] StStream = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

endpackage

// File: rtl/egress_skid_buf.sv
// Small synchronous FIFO holding frame words between the frame buffer read port and the
// AXI-stream output. Head is combinational; push and pop may coincide even when full.
module egress_skid_buf #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/frame_egress.sv
// Frame egress: rewinds the frame buffer read pointer to a descriptor's start, streams the
// frame out as 16-bit AXI-stream beats with tlast, and truncates cleanly on buffer underrun.
module frame_egress
  import frame_egress_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH:0]   cmd_start_ptr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic                  frame_rrst,
  output logic [ADDR_WIDTH:0]   frame_rst_rptr,
  output logic                  frame_ren,
  input  logic [19:0]           frame_rdata,
  input  logic                  last_entry,
  output axis_source_t          egress_pkt,
  input  logic                  egress_tready,
  output logic                  underrun,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(SKID_DEPTH) + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   start_q, start_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] rd_left_q, rd_left_d;
  logic [ADDR_WIDTH-1:0] tx_left_q, tx_left_d;
  logic                  inflight_q;
  logic                  underrun_q, underrun_d;

  logic [CntW-1:0]       skid_count;
  logic                  skid_empty;
  logic [15:0]           skid_head;
  logic [OccW-1:0]       occupancy;
  logic                  room;
  logic                  ren;
  logic                  pop;
  logic                  underrun_hit;
  logic                  unused_rdata_hi;

  assign unused_rdata_hi = ^frame_rdata[19:16];

  // A read still in flight will land in the buffer, so it already counts as occupied.
  assign occupancy    = {1'b0, skid_count} + {{CntW{1'b0}}, inflight_q};
  assign room         = occupancy < OccW'(SKID_DEPTH);
  assign ren          = (state_q == StStream) && (rd_left_q != '0) && room;
  assign pop          = !skid_empty && egress_tready;
  assign underrun_hit = ren && last_entry && (rd_left_q > ADDR_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    len_d      = len_q;
    rd_left_d  = rd_left_q;
    tx_left_d  = tx_left_q - ADDR_WIDTH'(pop);
    underrun_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          start_d = cmd_start_ptr;
          len_d   = cmd_len;
          if (cmd_len == '0) begin
            underrun_d = 1'b1;
          end else begin
            state_d = StRewind;
          end
        end
      end
      StRewind: begin
        rd_left_d = len_q;
        tx_left_d = len_q;
        state_d   = StStream;
      end
      StStream: begin
        if (underrun_hit) begin
          // Outstanding = issued (including this read) minus sent (including this pop).
          rd_left_d  = '0;
          tx_left_d  = tx_left_q - (rd_left_q - ADDR_WIDTH'(1)) - ADDR_WIDTH'(pop);
          underrun_d = 1'b1;
          state_d    = StDrain;
        end else if (ren) begin
          rd_left_d = rd_left_q - ADDR_WIDTH'(1);
          if (rd_left_q == ADDR_WIDTH'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && (tx_left_q == ADDR_WIDTH'(1))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      start_q    <= '0;
      len_q      <= '0;
      rd_left_q  <= '0;
      tx_left_q  <= '0;
      inflight_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      len_q      <= len_d;
      rd_left_q  <= rd_left_d;
      tx_left_q  <= tx_left_d;
      inflight_q <= ren;
      underrun_q <= underrun_d;
    end
  end

  egress_skid_buf #(
    .Depth (SKID_DEPTH),
    .Width (16)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .push_i      (inflight_q),
    .push_data_i (frame_rdata[15:0]),
    .pop_i       (pop),
    .head_o      (skid_head),
    .count_o     (skid_count),
    .empty_o     (skid_empty)
  );

  assign cmd_ready         = (state_q == StIdle);
  assign busy              = (state_q != StIdle);
  assign frame_rrst        = (state_q == StRewind);
  assign frame_rst_rptr    = start_q;
  assign frame_ren         = ren;
  assign underrun          = underrun_q;
  assign egress_pkt.tdata  = skid_head;
  assign egress_pkt.tvalid = !skid_empty;
  assign egress_pkt.tlast  = (tx_left_q == ADDR_WIDTH'(1));

endmodule
